pipe_cla_adder: RTL and testbench
=================================

PIPE_CLA_ADDER -- requirements
Module: pipe_cla_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: operand and sum width in bits.
REQ-002 The block SHALL have parameter BLK, default 4: bits per carry-lookahead block.
REQ-003 The block SHALL have parameter STAGES, default 2: number of pipeline register stages (latency in cycles).
REQ-004 The block SHALL have port clk, input, 1 bit: single clock, all state rising-edge.
REQ-005 The block SHALL have port rst, input, 1 bit: one clock; reset is asynchronous and active-high.
REQ-006 The block SHALL have port in_valid, input, 1 bit: operand beat present.
REQ-007 The block SHALL have port in_ready, output, 1 bit: stage 0 can accept.
REQ-008 The block SHALL have ports a and b, input, WIDTH bits each: operands.
REQ-009 The block SHALL have port cin, input, 1 bit: carry in (ignored when in_sub=1).
REQ-010 The block SHALL have port in_sub, input, 1 bit: 1 selects a - b.
REQ-011 The block SHALL have port out_valid, output, 1 bit: result present.
REQ-012 The block SHALL have port out_ready, input, 1 bit: consumer accepts.
REQ-013 The block SHALL have port s, output, WIDTH bits: sum/difference.
REQ-014 The block SHALL have port cout, output, 1 bit: carry out of MSB.
REQ-015 The block SHALL have port ovf, output, 1 bit: signed overflow (see Configuration).

Function
REQ-016 The block SHALL split the carry chain into STAGES equal segments of WIDTH/STAGES bits, each built from BLK-bit lookahead blocks rippling block carries.
REQ-017 Stage k SHALL compute segment k from the registered carry of stage k-1, register its sum slice, carry, and the not-yet-added operand slices.
REQ-018 Subtraction SHALL be formed as a + ~b + 1, i.e. b inverted and carry-in forced to 1 at capture.
REQ-019 A beat SHALL be accepted when in_valid && in_ready, and the result SHALL appear on out_valid exactly STAGES cycles later when no stall occurs.
REQ-020 Each stage SHALL hold a valid bit and SHALL advance when it is empty or its successor advances (bubble-collapsing pipeline).
REQ-021 in_ready SHALL equal (!v[0] || stage 0 advancing), computed combinationally from out_ready.
REQ-022 With out_valid=1 and out_ready=0, s, cout, ovf and out_valid SHALL hold stable.
REQ-023 Simultaneous accept at the input and drain at the output in one cycle SHALL sustain one result per cycle at full throughput.
REQ-024 Results SHALL leave in acceptance order, and no beat SHALL be dropped or duplicated.
REQ-025 Arithmetic SHALL be modulo 2^WIDTH, with cout the true carry out (for subtraction, cout=1 means no borrow).

Reset
REQ-026 On rst, all valid bits, s, cout and ovf SHALL clear to 0 asynchronously, and in_ready SHALL read 1 after the next edge without rst.
REQ-027 Reset mid-operation SHALL discard all in-flight beats, with no result emitted for them.

Configuration
REQ-028 With macro PIPE_CLA_OVF_EN defined, ovf SHALL be (a_msb == b'_msb) && (s_msb != a_msb), where b' is b after subtract inversion, and SHALL be aligned with s.
REQ-029 Without PIPE_CLA_OVF_EN, ovf SHALL be tied 0, its pipeline register and MSB carry logic SHALL be absent, and the port list SHALL be unchanged.

Structure
REQ-030 Package pipe_cla_pkg SHALL hold the default WIDTH/BLK/STAGES constants and the stage payload struct type (sum slice, carry, residual operands, ovf).
REQ-031 Sub-module cla_block SHALL implement one BLK-bit generate/propagate lookahead adder, instantiated per block.
REQ-032 Elaboration SHALL fail unless WIDTH % (BLK*STAGES) == 0.

Verification
REQ-033 Bench SHALL check: WIDTH=32, STAGES=2, a=0xFFFFFFFF, b=1, cin=0, add -> s=0x00000000, cout=1, out_valid exactly 2 cycles after accept.
REQ-034 Bench SHALL check: in_sub=1, a=5, b=7 -> s=0xFFFFFFFE, cout=0; a=7, b=5 -> s=2, cout=1.
REQ-035 Bench SHALL check with PIPE_CLA_OVF_EN: a=0x7FFFFFFF, b=1 add -> ovf=1; a=0x80000000, b=1 sub -> ovf=1; a=3, b=4 add -> ovf=0.
REQ-036 Bench SHALL check: 8 back-to-back beats with out_ready held 0 for 5 cycles -> in_ready drops after STAGES beats are held, outputs stay stable, then all 8 drain in order with no gaps.
REQ-037 Bench SHALL check: rst asserted with 2 beats in flight -> out_valid=0 immediately, and no stale result appears after release.
REQ-038 Bench SHALL check: 10k random beats with random out_ready, WIDTH in {16,32,64}, STAGES in {1,2,4} -> every result matches the reference model in order.

Source files
------------

// File: rtl/pipe_cla_pkg.sv
// Shared constants and per-stage payload type for the pipelined carry-lookahead adder.
// The payload is sized for the widest supported operand; narrower builds leave upper bits at zero.
package pipe_cla_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_BLK    = 4;
    localparam int DEF_STAGES = 2;
    localparam int PL_MAX_W   = 64;

    // sum fills from the top down, one segment per stage; opa/opb shift down as segments are consumed
    typedef struct packed {
        logic [PL_MAX_W-1:0] sum;
        logic [PL_MAX_W-1:0] opa;
        logic [PL_MAX_W-1:0] opb;
        logic                carry;
        logic                ovf;
    } cla_stage_t;

endpackage

// File: rtl/pipe_cla_adder_cla_block.sv
// One BLK-bit generate/propagate carry-lookahead adder; every internal carry is a flat
// sum-of-products of g, p and the block carry-in.
module cla_block #(
    parameter int BLK = 4
) (
    input  logic [BLK-1:0] i_a,
    input  logic [BLK-1:0] i_b,
    input  logic           i_c,
    output logic [BLK-1:0] o_s,
    output logic           o_c
);

    logic [BLK-1:0] w_g;
    logic [BLK-1:0] w_p;
    logic [BLK:0]   w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    always_comb begin
        logic w_term;
        logic w_pp;
        w_c    = '0;
        w_term = 1'b0;
        w_pp   = 1'b1;
        w_c[0] = i_c;
        for (int i = 0; i < BLK; i++) begin
            w_term = w_g[i];
            w_pp   = w_p[i];
            for (int j = i - 1; j >= 0; j--) begin
                w_term = w_term | (w_pp & w_g[j]);
                w_pp   = w_pp & w_p[j];
            end
            w_c[i+1] = w_term | (w_pp & i_c);
        end
    end

    assign o_s = w_p ^ w_c[BLK-1:0];
    assign o_c = w_c[BLK];

endmodule

// File: rtl/pipe_cla_adder.sv
// Pipelined add/subtract: STAGES carry segments, each built from rippled cla_block lookahead blocks,
// with a bubble-collapsing valid/ready pipeline. Define PIPE_CLA_OVF_EN to produce signed overflow.
module pipe_cla_adder
    import pipe_cla_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int BLK    = DEF_BLK,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int NBLK = SEG / BLK;

    if (WIDTH % (BLK * STAGES) != 0) begin : g_bad_geom
        $error("pipe_cla_adder: WIDTH must be a multiple of BLK*STAGES");
    end
    if (WIDTH > PL_MAX_W) begin : g_bad_width
        $error("pipe_cla_adder: WIDTH exceeds payload capacity");
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        cla_stage_t     w_src;
        cla_stage_t     w_nxt;
        cla_stage_t     r_stage;
        logic           r_v;
        logic           w_vin;
        logic           w_adv;
        logic           w_ovf;
        logic [SEG-1:0] w_sum;

        // subtraction is folded in at capture: b inverted, carry-in forced to 1
        if (k == 0) begin : g_head
            always_comb begin
                w_src                = '0;
                w_src.opa[WIDTH-1:0] = a;
                w_src.opb[WIDTH-1:0] = in_sub ? ~b : b;
                w_src.carry          = in_sub | cin;
            end
            assign w_vin = in_valid;
        end else begin : g_body
            assign w_src = g_stage[k-1].r_stage;
            assign w_vin = g_stage[k-1].r_v;
        end

        if (k == STAGES - 1) begin : g_tail
            assign w_adv = !r_v || out_ready;
        end else begin : g_mid
            assign w_adv = !r_v || g_stage[k+1].w_adv;
        end

        for (genvar j = 0; j < NBLK; j++) begin : g_blk
            logic w_ci;
            logic w_co;
            if (j == 0) begin : g_c0
                assign w_ci = w_src.carry;
            end else begin : g_cn
                assign w_ci = g_blk[j-1].w_co;
            end
            cla_block #(.BLK(BLK)) u_cla (
                .i_a (w_src.opa[j*BLK +: BLK]),
                .i_b (w_src.opb[j*BLK +: BLK]),
                .i_c (w_ci),
                .o_s (w_sum[j*BLK +: BLK]),
                .o_c (w_co)
            );
        end

`ifdef PIPE_CLA_OVF_EN
        if (k == STAGES - 1) begin : g_ovf
            assign w_ovf = (w_src.opa[SEG-1] == w_src.opb[SEG-1]) && (w_sum[SEG-1] != w_src.opa[SEG-1]);
        end else begin : g_no_ovf
            assign w_ovf = 1'b0;
        end
`else
        assign w_ovf = 1'b0;
`endif

        always_comb begin
            w_nxt                         = '0;
            w_nxt.sum                     = w_src.sum >> SEG;
            w_nxt.sum[PL_MAX_W-1 -: SEG]  = w_sum;
            w_nxt.opa                     = w_src.opa >> SEG;
            w_nxt.opb                     = w_src.opb >> SEG;
            w_nxt.carry                   = g_blk[NBLK-1].w_co;
            w_nxt.ovf                     = w_ovf;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_v     <= 1'b0;
                r_stage <= '0;
            end else if (w_adv) begin
                r_v     <= w_vin;
                r_stage <= w_nxt;
            end
        end
    end

    assign in_ready  = g_stage[0].w_adv;
    assign out_valid = g_stage[STAGES-1].r_v;
    assign s         = g_stage[STAGES-1].r_stage.sum[PL_MAX_W-1 -: WIDTH];
    assign cout      = g_stage[STAGES-1].r_stage.carry;
`ifdef PIPE_CLA_OVF_EN
    assign ovf       = g_stage[STAGES-1].r_stage.ovf;
`else
    assign ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_cla_adder.sv
// Self-checking bench for pipe_cla_adder: directed vectors on a 32-bit/2-stage instance,
// then random traffic with random backpressure on 16/1, 32/2 and 64/4 instances.
module tb_pipe_cla_adder;

`ifdef PIPE_CLA_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif
    localparam int NB = 3400;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, cin, in_sub;
    logic        out_valid, out_ready, cout, ovf;
    logic [31:0] a, b, s;
    int          n_tot = 0;
    int          n_bad = 0;
    bit          go_rnd = 1'b0;

    always #5 clk = ~clk;

    pipe_cla_adder #(.WIDTH(32), .BLK(4), .STAGES(2)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready), .s(s), .cout(cout), .ovf(ovf)
    );

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] pack_res(input logic o, input logic c, input logic [63:0] sv);
        return {6'b0, o, c, sv};
    endfunction

    function automatic logic [71:0] ref_add(input int w, input logic [63:0] x, input logic [63:0] y,
                                            input logic ci, input logic sb);
        logic [63:0] mask, yy, sv;
        logic [64:0] full;
        logic        c, o;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        yy   = (sb ? ~y : y) & mask;
        full = {1'b0, x & mask} + {1'b0, yy} + {64'd0, sb | ci};
        sv   = full[63:0] & mask;
        c    = full[w];
        o    = OVF_EN && (x[w-1] == yy[w-1]) && (sv[w-1] != x[w-1]);
        return pack_res(o, c, sv);
    endfunction

    task automatic beat(input string tag, input logic [31:0] x, input logic [31:0] y, input logic ci,
                        input logic sb, input logic [31:0] es, input logic ec, input logic eo);
        int lat;
        @(negedge clk);
        a = x; b = y; cin = ci; in_sub = sb; in_valid = 1'b1; out_ready = 1'b1;
        #1 chk({tag, "_rdy"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        #1;
        while (!out_valid && lat < 8) begin
            @(negedge clk);
            #1 lat++;
        end
        chk({tag, "_lat"}, lat, 2);
        chk({tag, "_s"}, s, es);
        chk({tag, "_cout"}, cout, ec);
        chk({tag, "_ovf"}, ovf, eo && OVF_EN);
    endtask

    task automatic stall_test();
        logic [71:0] exp[8];
        logic [31:0] xi;
        int nb, nr, cyc;
        for (int i = 0; i < 8; i++) begin
            xi = 32'(i) * 32'h1111_1111;
            exp[i] = ref_add(32, 64'(xi), 64'h0F0F_0F0F, 1'(i % 2), 1'b0);
        end
        nb = 0; nr = 0; cyc = 0;
        while (nr < 8 && cyc < 40) begin
            @(negedge clk);
            out_ready = (cyc >= 5);
            in_valid  = (nb < 8);
            a = 32'(nb) * 32'h1111_1111; b = 32'h0F0F_0F0F; cin = 1'(nb % 2); in_sub = 1'b0;
            #1;
            if (cyc == 2) chk("stall_rdy", in_ready, 0);
            if (cyc >= 2 && cyc <= 4) begin
                chk("stall_hold_v", out_valid, 1);
                chk("stall_hold_s", pack_res(ovf, cout, 64'(s)), exp[0]);
            end
            if (cyc >= 5) chk("stall_nogap", out_valid, 1);
            if (out_valid && out_ready) begin
                chk("stall_order", pack_res(ovf, cout, 64'(s)), exp[nr]);
                nr++;
            end
            if (in_valid && in_ready) nb++;
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("stall_cnt", nr, 8);
    endtask

    task automatic reset_test();
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; a = 32'd1; b = 32'd2; cin = 1'b0; in_sub = 1'b0;
        @(negedge clk);
        a = 32'd3;
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("rst_pre_v", out_valid, 1);
        #1 rst = 1'b1;
        #1 chk("rst_async_v", out_valid, 0);
        chk("rst_async_s", s, 0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1 chk("rst_stale", out_valid, 0);
        end
        chk("rst_rdy", in_ready, 1);
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_rnd
        localparam int W = (g == 0) ? 16 : (g == 1) ? 32 : 64;
        localparam int S = (g == 0) ? 1 : (g == 1) ? 2 : 4;
        localparam int B = (g == 2) ? 8 : 4;
        logic         rv, rrdy, rci, rsb, ovld, ordy, rco, rovf;
        logic [W-1:0] ra, rb, rs;
        bit           done = 1'b0;

        pipe_cla_adder #(.WIDTH(W), .BLK(B), .STAGES(S)) u_dut (
            .clk(clk), .rst(rst), .in_valid(rv), .in_ready(rrdy),
            .a(ra), .b(rb), .cin(rci), .in_sub(rsb),
            .out_valid(ovld), .out_ready(ordy), .s(rs), .cout(rco), .ovf(rovf)
        );

        function automatic logic [W-1:0] pick();
            logic [63:0] rr;
            rr = {$urandom(), $urandom()};
            case ($urandom_range(7))
                0:       return '1;
                1:       return '0;
                2:       return W'(64'd1 << (W - 1));
                default: return rr[W-1:0];
            endcase
        endfunction

        initial begin
            logic [71:0] q[$];
            logic [71:0] e;
            int sent, cyc;
            rv = 1'b0; ra = '0; rb = '0; rci = 1'b0; rsb = 1'b0; ordy = 1'b1;
            sent = 0; cyc = 0;
            wait (go_rnd);
            while ((sent < NB || q.size() != 0) && cyc < NB * 10) begin
                @(negedge clk);
                rv   = (sent < NB) && ($urandom_range(3) != 0);
                ra   = pick();
                rb   = pick();
                rci  = 1'($urandom_range(1));
                rsb  = 1'($urandom_range(1));
                ordy = ($urandom_range(3) != 0);
                #1;
                if (ovld && ordy) begin
                    e = (q.size() != 0) ? q.pop_front() : '1;
                    chk($sformatf("rnd_w%0d_s%0d", W, S), pack_res(rovf, rco, 64'(rs)), e);
                end
                if (rv && rrdy) begin
                    q.push_back(ref_add(W, 64'(ra), 64'(rb), rci, rsb));
                    sent++;
                end
                cyc++;
            end
            chk($sformatf("rnd_sent_w%0d", W), sent, NB);
            chk($sformatf("rnd_left_w%0d", W), q.size(), 0);
            rv = 1'b0;
            done = 1'b1;
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; in_sub = 1'b0;
        #3;
        chk("reset_v", out_valid, 0);
        chk("reset_s", s, 0);
        chk("reset_cout", cout, 0);
        chk("reset_ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1 chk("reset_rdy", in_ready, 1);

        beat("wrap",      32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        beat("sub_5_7",   32'd5,         32'd7,         1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        beat("sub_7_5",   32'd7,         32'd5,         1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
        beat("ovf_add",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        beat("ovf_sub",   32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        beat("add_3_4",   32'd3,         32'd4,         1'b0, 1'b0, 32'h0000_0007, 1'b0, 1'b0);
        beat("seg_carry", 32'h0000_FFFF, 32'h0000_FFFF, 1'b1, 1'b0, 32'h0001_FFFF, 1'b0, 1'b0);
        beat("sub_cin",   32'd10,        32'd3,         1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0);

        stall_test();
        reset_test();

        go_rnd = 1'b1;
        for (int i = 0; i < 40000 && !(g_rnd[0].done && g_rnd[1].done && g_rnd[2].done); i++)
            @(negedge clk);
        chk("rnd_done", {g_rnd[0].done, g_rnd[1].done, g_rnd[2].done}, 3'b111);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=running exp=finished");
        $fatal(1);
    end

endmodule
